conv2d_stream_engine: RTL and testbench

//  Streaming 2-D convolution of a raster-scan pixel stream with a programmable KxK kernel.

---
 rtl/conv2d_stream_engine.sv | 207 ++++++++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream_engine.sv
// Streaming KxK "valid"-mode convolution over a raster-scan pixel stream.
// K-1 line buffers feed a KxK window. Two pipeline stages follow the window:
// the multipliers, then the adder tree with shift and saturate.
//
// state | meaning
// IDLE  | waiting for start; coefficient writes accepted here only
// RUN   | accepting pixels until the last pixel of the frame
// FLUSH | draining results still in the pipeline
// DONE  | one-cycle done pulse, then back to IDLE
module conv2d_stream_engine #(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int K        = 3,
    parameter int MAX_COLS = 1024,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [9:0]                    cfg_rows,
    input  logic [$clog2(MAX_COLS):0]     cfg_cols,
    input  logic [4:0]                    cfg_shift,
    input  logic                          start,
    input  logic                          coef_we,
    input  logic [5:0]                    coef_addr,
    input  logic signed [COEF_W-1:0]      coef_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);
    localparam int CW = $clog2(MAX_COLS) + 1;
    localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int NT = K * K;
    localparam int PW = DATA_W + COEF_W;
    localparam int LB = (K > 1) ? K - 1 : 1;

    localparam logic [9:0]    K_R   = 10'(K);
    localparam logic [9:0]    K1_R  = 10'(K - 1);
    localparam logic [CW-1:0] K_C   = CW'(K);
    localparam logic [CW-1:0] K1_C  = CW'(K - 1);
    localparam logic [CW-1:0] MAXC  = CW'(MAX_COLS);
    localparam logic [5:0]    NT_A  = 6'(NT);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state, state_nxt;

    logic [9:0]    rows_q, row;
    logic [CW-1:0] cols_q, col;
    logic [4:0]    shift_q;

    logic signed [COEF_W-1:0] coef [NT];
    logic signed [DATA_W-1:0] lbuf [LB][MAX_COLS];
    logic signed [DATA_W-1:0] win  [K][K];
    logic signed [DATA_W-1:0] colvec [K];
    logic signed [PW-1:0]     prod [NT];
    logic                     v0, v1;

    logic adv, accept, last_col, last_pix, complete, cfg_ok;
    logic [AW-1:0] col_a;
    logic signed [ACC_W-1:0] acc, shifted;
    logic signed [OUT_W-1:0] sat;

    assign adv      = !out_valid || out_ready;
    assign in_ready = (state == RUN) && adv;
    assign accept   = in_valid && in_ready;
    assign last_col = (col == cols_q - CW'(1));
    assign last_pix = accept && last_col && (row == rows_q - 10'd1);
    assign complete = (row >= K1_R) && (col >= K1_C);
    assign cfg_ok   = (cfg_rows >= K_R) && (cfg_cols >= K_C) && (cfg_cols <= MAXC);
    assign col_a    = col[AW-1:0];
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; FLUSH ends when the final result leaves an otherwise empty pipe
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && cfg_ok) state_nxt = RUN;
            RUN:     if (last_pix) state_nxt = FLUSH;
            FLUSH:   if (out_valid && out_ready && !v0 && !v1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame configuration capture, error flag and raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q  <= '0;
            cols_q  <= '0;
            shift_q <= '0;
            row     <= '0;
            col     <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cfg_err <= !cfg_ok;
                if (cfg_ok) begin
                    rows_q  <= cfg_rows;
                    cols_q  <= cfg_cols;
                    shift_q <= cfg_shift;
                    row     <= '0;
                    col     <= '0;
                end
            end else if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= row + 10'd1;
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Coefficient file, writable only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NT; t++) coef[t] <= '0;
        end else if (state == IDLE && coef_we && coef_addr < NT_A) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // New window column: oldest row at index 0, incoming pixel at the bottom
    always_comb begin
        for (int i = 0; i < K; i++) colvec[i] = '0;
        for (int i = 0; i < K - 1; i++) colvec[i] = lbuf[K - 2 - i][col_a];
        colvec[K-1] = in_data;
    end

    // Line buffers shift a column down by one row on every accepted pixel
    always_ff @(posedge clk) begin
        if (accept) begin
            lbuf[0][col_a] <= in_data;
            for (int k = 1; k < K - 1; k++) lbuf[k][col_a] <= lbuf[k-1][col_a];
        end
    end

    // Window shift register; cleared on column 0 so no data wraps across rows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) win[i][j] <= '0;
            v0 <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K - 1; j++)
                        win[i][j] <= (col == '0) ? '0 : win[i][j+1];
                    win[i][K-1] <= colvec[i];
                end
            end
            if (adv) v0 <= accept && complete;
        end
    end

    // Stage 1: KxK signed products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NT; t++) prod[t] <= '0;
            v1 <= 1'b0;
        end else if (adv) begin
            v1 <= v0;
            if (v0)
                for (int t = 0; t < NT; t++)
                    prod[t] <= PW'(win[t / K][t % K]) * PW'(coef[t]);
        end
    end

    // Adder tree, arithmetic shift and saturation
    always_comb begin
        acc = '0;
        for (int t = 0; t < NT; t++)
            acc = acc + {{(ACC_W - PW){prod[t][PW-1]}}, prod[t]};
        shifted = acc >>> shift_q;
        if (shifted > SAT_HI)      sat = SAT_HI[OUT_W-1:0];
        else if (shifted < SAT_LO) sat = SAT_LO[OUT_W-1:0];
        else                       sat = shifted[OUT_W-1:0];
    end

    // Stage 2: output register, held until the sink accepts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= v1;
            if (v1) out_data <= sat;
        end
    end
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine (K=3, 8-bit data/coefs, 16-bit out).
module tb_conv2d_stream_engine;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [9:0]         cfg_rows = '0;
    logic [10:0]        cfg_cols = '0;
    logic [4:0]         cfg_shift = '0;
    logic               start = 1'b0;
    logic               coef_we = 1'b0;
    logic [5:0]         coef_addr = '0;
    logic signed [7:0]  coef_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [7:0]  in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_data;
    logic               busy, done, cfg_err;

    int checks = 0;
    int errors = 0;
    int pix_q[$];
    int exp_q[$];
    int got_q[$];
    int first_out_it, lat_acc_it;
    logic [15:0] lfsr = 16'hACE1;

    conv2d_stream_engine dut (
        .clk(clk), .rst(rst), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .cfg_shift(cfg_shift), .start(start), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_coef(input int addr, input int val);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 6'(addr); coef_data = 8'(val);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic set_all_coefs(input int val);
        for (int t = 0; t < 9; t++) write_coef(t, val);
    endtask

    task automatic do_start(input int rows, input int cols, input int shift);
        @(negedge clk);
        cfg_rows = 10'(rows); cfg_cols = 11'(cols); cfg_shift = 5'(shift); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds pix_q, collects results, checks them against exp_q.
    // mode 0: continuous; mode 1: gappy in_valid and toggling out_ready.
    task automatic run_frame(input string tag, input int mode, input int cols);
        int idx = 0;
        int done_cnt = 0;
        int it = 0;
        int post = -1;
        int lat_idx = 2 * cols + 2;
        int obs;
        bit fin = 1'b0;
        got_q.delete();
        first_out_it = -1;
        lat_acc_it = -1;
        while (!fin && it < 3000) begin
            @(negedge clk);
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            out_ready = (mode == 0) ? 1'b1 : lfsr[0];
            if (idx < pix_q.size() && (mode == 0 || lfsr[3] || lfsr[6])) begin
                in_valid = 1'b1;
                in_data  = 8'(pix_q[idx]);
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
            #1;
            if (out_valid && first_out_it < 0) first_out_it = it;
            if (out_valid && out_ready) got_q.push_back(int'(out_data));
            if (in_valid && in_ready) begin
                if (idx == lat_idx) lat_acc_it = it;
                idx++;
            end
            if (done) done_cnt++;
            if (post >= 0) post++;
            else if (done) post = 0;
            if (post == 3) fin = 1'b1;
            it++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk({tag, " finished"}, int'(fin), 1);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " busy_after"}, int'(busy), 0);
        chk({tag, " count"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            obs = (i < got_q.size()) ? got_q[i] : -999999;
            chk($sformatf("%s result%0d", tag, i), obs, exp_q[i]);
        end
    endtask

    initial begin
        int idx;
        int it;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready", int'(in_ready), 0);
        chk("reset cfg_err", int'(cfg_err), 0);
        chk("reset out_data", int'(out_data), 0);

        // 4x4 ramp, all-ones kernel
        set_all_coefs(1);
        do_start(4, 4, 0);
        pix_q.delete(); for (int p = 1; p <= 16; p++) pix_q.push_back(p);
        exp_q = '{54, 63, 90, 99};
        run_frame("t1", 0, 4);
        chk("t1 latency", first_out_it - lat_acc_it, 3);

        // identity kernel on a 5x5 ramp
        for (int t = 0; t < 9; t++) write_coef(t, (t == 4) ? 1 : 0);
        do_start(5, 5, 0);
        pix_q.delete(); for (int p = 1; p <= 25; p++) pix_q.push_back(p);
        exp_q = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
        run_frame("t2", 0, 5);

        // backpressure and gappy input must not change the sequence
        set_all_coefs(1);
        do_start(4, 4, 0);
        pix_q.delete(); for (int p = 1; p <= 16; p++) pix_q.push_back(p);
        exp_q = '{54, 63, 90, 99};
        run_frame("t3", 1, 4);

        // arithmetic shift by 2 truncates 13.5 -> 13 etc.
        do_start(4, 4, 2);
        exp_q = '{13, 15, 22, 24};
        run_frame("t1_shift", 0, 4);

        // saturation both ways
        set_all_coefs(127);
        do_start(3, 3, 0);
        pix_q.delete(); for (int p = 0; p < 9; p++) pix_q.push_back(127);
        exp_q = '{32767};
        run_frame("t4_pos", 0, 3);
        do_start(3, 3, 0);
        pix_q.delete(); for (int p = 0; p < 9; p++) pix_q.push_back(-128);
        exp_q = '{-32768};
        run_frame("t4_neg", 0, 3);

        // rejected configurations
        do_start(4, 2, 0);
        #1;
        chk("t5 cfg_err cols2", int'(cfg_err), 1);
        chk("t5 busy cols2", int'(busy), 0);
        do_start(4, 1025, 0);
        #1;
        chk("t5 cfg_err cols1025", int'(cfg_err), 1);
        chk("t5 busy cols1025", int'(busy), 0);

        // good start clears cfg_err; coefficient write in RUN is dropped
        set_all_coefs(1);
        do_start(3, 3, 0);
        #1;
        chk("t5 cfg_err cleared", int'(cfg_err), 0);
        chk("t5 busy run", int'(busy), 1);
        write_coef(0, 100);
        pix_q.delete(); for (int p = 0; p < 9; p++) pix_q.push_back(1);
        exp_q = '{9};
        run_frame("t5_coef", 0, 3);

        // reset after 7 pixels of a 4x4 frame
        do_start(4, 4, 0);
        idx = 0;
        it = 0;
        while (idx < 7 && it < 100) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(idx + 1);
            #1;
            if (in_ready) idx++;
            it++;
        end
        chk("t6 fed", idx, 7);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6 busy", int'(busy), 0);
        chk("t6 out_valid", int'(out_valid), 0);
        chk("t6 in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        set_all_coefs(1);
        do_start(4, 4, 0);
        pix_q.delete(); for (int p = 1; p <= 16; p++) pix_q.push_back(p);
        exp_q = '{54, 63, 90, 99};
        run_frame("t6_after", 0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
